// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default frame geometry.
package uart_pkg;
  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;
endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; RST_VAL sets the reset level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 frames into a valid/ready byte register.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_s;
  uart_state_e          state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr, cnt_inc, shift, stop_ok, stop_bad, half, full;

  sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset_n(reset_n), .d(rx), .q(rx_s));

  assign half = (cnt == CW'(OVERSAMPLE/2 - 1));
  assign full = (cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift     = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    if (rx_en) begin
      unique case (state)
        ST_IDLE: if (!rx_s) begin state_nxt = ST_START; cnt_clr = 1'b1; end
        // Mid-bit recheck of the start bit rejects short low glitches.
        ST_START: if (half) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end else cnt_inc = 1'b1;
        ST_DATA: if (full) begin
          cnt_clr = 1'b1;
          shift   = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == BW'(DATA_BITS - 1)) state_nxt = ST_PARITY;
`else
          if (bit_idx == BW'(DATA_BITS - 1)) state_nxt = ST_STOP;
`endif
        end else cnt_inc = 1'b1;
        ST_PARITY: if (full) begin cnt_clr = 1'b1; state_nxt = ST_STOP; end
                   else cnt_inc = 1'b1;
        ST_STOP: if (full) begin
          cnt_clr = 1'b1;
          if (rx_s) begin stop_ok  = 1'b1; state_nxt = ST_IDLE;      end
          else      begin stop_bad = 1'b1; state_nxt = ST_WAIT_HIGH; end
        end else cnt_inc = 1'b1;
        // A held-low break must see the line high before a new start is armed.
        ST_WAIT_HIGH: if (rx_s) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (shift) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end else if (state != ST_DATA) begin
        bit_idx <= '0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rx_en && state == ST_PARITY && full) par_bit <= rx_s;
      parity_err <= stop_ok & (par_bit ^ (^shreg));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (stop_ok) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule
